// File: rtl/cheri_pkg.sv
// Shared CHERI types for the TSMAP arbiter: bus op encoding, sequencer states,
// response source select and the bit-op word update helper.
package cheri_pkg;

  localparam int unsigned TSMAP_SIZE = 1024;

  typedef enum logic [1:0] {
    TSMAP_OP_PLAIN = 2'b00,
    TSMAP_OP_SET   = 2'b01,
    TSMAP_OP_CLR   = 2'b10,
    TSMAP_OP_RSVD  = 2'b11
  } tsmap_op_e;

  typedef enum logic {
    TSMAP_ST_IDLE   = 1'b0,
    TSMAP_ST_RMW_WR = 1'b1
  } tsmap_state_e;

  typedef enum logic [1:0] {
    TSMAP_RSP_ZERO = 2'b00,
    TSMAP_RSP_SRAM = 2'b01,
    TSMAP_RSP_OLD  = 2'b10
  } tsmap_rsp_e;

  function automatic logic [31:0] tsmap_bitop(input tsmap_op_e   op,
                                              input logic [31:0] old_w,
                                              input logic [31:0] mask);
    logic [31:0] res;
    res = old_w;
    if (op == TSMAP_OP_SET) res = old_w | mask;
    else if (op == TSMAP_OP_CLR) res = old_w & ~mask;
    return res;
  endfunction

endpackage

// File: rtl/cheri_tsmap_arb_if.sv
// Bus requester port of the TSMAP arbiter. Handshake: the master holds
// bus_req_i and its payload stable until bus_gnt_o is seen high in the same cycle;
// exactly one bus_rvalid_o pulse follows each grant; bus_err_o/bus_rdata_o are
// meaningful only while bus_rvalid_o is high.
interface cheri_tsmap_arb_if;
  logic        bus_req_i;
  logic        bus_we_i;
  logic [1:0]  bus_op_i;
  logic [15:0] bus_addr_i;
  logic [31:0] bus_wdata_i;
  logic [3:0]  bus_be_i;
  logic        bus_gnt_o;
  logic        bus_rvalid_o;
  logic [31:0] bus_rdata_o;
  logic        bus_err_o;

  modport master (
    output bus_req_i, bus_we_i, bus_op_i, bus_addr_i, bus_wdata_i, bus_be_i,
    input  bus_gnt_o, bus_rvalid_o, bus_rdata_o, bus_err_o
  );

  modport slave (
    input  bus_req_i, bus_we_i, bus_op_i, bus_addr_i, bus_wdata_i, bus_be_i,
    output bus_gnt_o, bus_rvalid_o, bus_rdata_o, bus_err_o
  );
endinterface

// File: rtl/cheri_tsmap_rmw.sv
// Bit-op read-modify-write datapath: latches address/mask/op at grant, captures
// the pre-update word on the first RMW_WR cycle and forms the new word.
module cheri_tsmap_rmw
  import cheri_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_load,
  input  logic [15:0] i_addr,
  input  logic [31:0] i_mask,
  input  tsmap_op_e   i_op,
  input  logic [31:0] i_rdata,
  output logic [15:0] o_addr,
  output logic [31:0] o_wdata,
  output logic [31:0] o_old_q
);

  logic [15:0] r_addr;
  logic [31:0] r_mask;
  tsmap_op_e   r_op;
  logic [31:0] r_old_q;
  logic        r_cap;
  logic [31:0] w_old;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_mask  <= '0;
      r_op    <= TSMAP_OP_PLAIN;
      r_old_q <= '0;
      r_cap   <= 1'b0;
    end else begin
      r_cap <= i_load;
      if (i_load) begin
        r_addr <= i_addr;
        r_mask <= i_mask;
        r_op   <= i_op;
      end
      if (r_cap) r_old_q <= i_rdata;
    end
  end

  // SRAM data is only ours on the entry cycle; later cycles may carry revocation reads.
  assign w_old   = r_cap ? i_rdata : r_old_q;
  assign o_addr  = r_addr;
  assign o_wdata = tsmap_bitop(r_op, w_old, r_mask);
  assign o_old_q = r_old_q;

endmodule

// File: rtl/cheri_tsmap_arb.sv
// Single-port TSMAP SRAM arbiter: revocation reads always win, bus accesses use
// free cycles. Bit-set/clear RMW sequencing is built only with TSMAP_BITOP_EN.
module cheri_tsmap_arb
  import cheri_pkg::*;
#(
  parameter int unsigned TSMapSize = TSMAP_SIZE
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              trvk_cs_i,
  input  logic [15:0]       trvk_addr_i,
  output logic [31:0]       trvk_rdata_o,
  cheri_tsmap_arb_if.slave  bus,
  output logic              sram_cs_o,
  output logic              sram_we_o,
  output logic [15:0]       sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  output logic [3:0]        sram_be_o,
  input  logic [31:0]       sram_rdata_i,
  input  logic              cnt_clr_i,
  output logic [15:0]       conflict_cnt_o,
  output tsmap_state_e      dbg_state_o
);

  tsmap_state_e r_state, w_state_d;
  tsmap_op_e    w_op;
  tsmap_rsp_e   r_rsp, w_rsp_d;
  logic         w_in_range, w_bitop, w_err_acc, w_gnt, w_start_rmw, w_wr_go;
  logic         r_rvalid, r_err, w_rvalid_d, w_err_d;
  logic [15:0]  r_cnt;
  logic [15:0]  w_rmw_addr;
  logic [31:0]  w_rmw_wdata, w_old_q;

  assign w_op       = tsmap_op_e'(bus.bus_op_i);
  assign w_in_range = ({16'h0, bus.bus_addr_i} < TSMapSize);

`ifdef TSMAP_BITOP_EN
  assign w_bitop   = bus.bus_we_i & ((w_op == TSMAP_OP_SET) | (w_op == TSMAP_OP_CLR));
  assign w_err_acc = ~w_in_range | (bus.bus_we_i & (w_op == TSMAP_OP_RSVD));

  cheri_tsmap_rmw u_rmw (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_load  (w_start_rmw),
    .i_addr  (bus.bus_addr_i),
    .i_mask  (bus.bus_wdata_i),
    .i_op    (w_op),
    .i_rdata (sram_rdata_i),
    .o_addr  (w_rmw_addr),
    .o_wdata (w_rmw_wdata),
    .o_old_q (w_old_q)
  );
`else
  // Without RMW support every non-plain write is answered with an error.
  assign w_bitop     = 1'b0;
  assign w_err_acc   = ~w_in_range | (bus.bus_we_i & (w_op != TSMAP_OP_PLAIN));
  assign w_rmw_addr  = '0;
  assign w_rmw_wdata = '0;
  assign w_old_q     = '0;
`endif

  assign w_gnt       = bus.bus_req_i & ~trvk_cs_i & (r_state == TSMAP_ST_IDLE);
  assign w_start_rmw = w_gnt & w_bitop & ~w_err_acc;
  assign w_wr_go     = (r_state == TSMAP_ST_RMW_WR) & ~trvk_cs_i;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      TSMAP_ST_IDLE:   if (w_start_rmw) w_state_d = TSMAP_ST_RMW_WR;
      TSMAP_ST_RMW_WR: if (w_wr_go) w_state_d = TSMAP_ST_IDLE;
      default:         w_state_d = TSMAP_ST_IDLE;
    endcase
  end

  always_comb begin
    w_rvalid_d = 1'b0;
    w_err_d    = 1'b0;
    w_rsp_d    = TSMAP_RSP_ZERO;
    if (w_wr_go) begin
      w_rvalid_d = 1'b1;
      w_rsp_d    = TSMAP_RSP_OLD;
    end else if (w_gnt & ~w_start_rmw) begin
      w_rvalid_d = 1'b1;
      w_err_d    = w_err_acc;
      if (~w_err_acc & ~bus.bus_we_i) w_rsp_d = TSMAP_RSP_SRAM;
    end
  end

  // One SRAM port: revocation, then pending RMW write, then a fresh bus grant.
  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (trvk_cs_i) begin
      sram_cs_o   = 1'b1;
      sram_addr_o = trvk_addr_i;
    end else if (r_state == TSMAP_ST_RMW_WR) begin
      sram_cs_o    = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = w_rmw_addr;
      sram_wdata_o = w_rmw_wdata;
      sram_be_o    = 4'hF;
    end else if (w_gnt & ~w_err_acc) begin
      sram_cs_o   = 1'b1;
      sram_we_o   = bus.bus_we_i & ~w_bitop;
      sram_addr_o = bus.bus_addr_i;
      if (bus.bus_we_i & ~w_bitop) begin
        sram_wdata_o = bus.bus_wdata_i;
        sram_be_o    = bus.bus_be_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= TSMAP_ST_IDLE;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rsp    <= TSMAP_RSP_ZERO;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_rvalid <= w_rvalid_d;
      r_err    <= w_err_d;
      r_rsp    <= w_rsp_d;
      if (cnt_clr_i) r_cnt <= '0;
      else if (bus.bus_req_i & ~w_gnt & (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
    end
  end

  always_comb begin
    bus.bus_rdata_o = '0;
    if (r_rvalid) begin
      unique case (r_rsp)
        TSMAP_RSP_SRAM: bus.bus_rdata_o = sram_rdata_i;
        TSMAP_RSP_OLD:  bus.bus_rdata_o = w_old_q;
        default:        bus.bus_rdata_o = '0;
      endcase
    end
  end

  assign bus.bus_gnt_o    = w_gnt;
  assign bus.bus_rvalid_o = r_rvalid;
  assign bus.bus_err_o    = r_err;
  assign trvk_rdata_o     = sram_rdata_i;
  assign conflict_cnt_o   = r_cnt;
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_cheri_tsmap_arb.sv
// Bench for cheri_tsmap_arb: vector table of bus transactions through a scoreboard
// queue, plus hand-written arbitration, RMW-blocking and counter sequences.
module tb_cheri_tsmap_arb;
  import cheri_pkg::*;

`ifdef TSMAP_BITOP_EN
  localparam bit BITOP = 1'b1;
`else
  localparam bit BITOP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         trvk_cs = 1'b0;
  logic [15:0]  trvk_addr = '0;
  logic [31:0]  trvk_rdata;
  logic         sram_cs, sram_we;
  logic [15:0]  sram_addr;
  logic [31:0]  sram_wdata;
  logic [3:0]   sram_be;
  logic [31:0]  sram_rdata = '0;
  logic         cnt_clr = 1'b0;
  logic [15:0]  conflict_cnt;
  tsmap_state_e dbg_state;

  logic [31:0]  mem [0:1023];
  logic [32:0]  exp_q[$];
  vec_t         vecs[16];
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  cheri_tsmap_arb_if bus_if ();

  cheri_tsmap_arb #(.TSMapSize(1024)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .trvk_cs_i      (trvk_cs),
    .trvk_addr_i    (trvk_addr),
    .trvk_rdata_o   (trvk_rdata),
    .bus            (bus_if),
    .sram_cs_o      (sram_cs),
    .sram_we_o      (sram_we),
    .sram_addr_o    (sram_addr),
    .sram_wdata_o   (sram_wdata),
    .sram_be_o      (sram_be),
    .sram_rdata_i   (sram_rdata),
    .cnt_clr_i      (cnt_clr),
    .conflict_cnt_o (conflict_cnt),
    .dbg_state_o    (dbg_state)
  );

  // Single-port SRAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (sram_cs && (sram_addr < 16'd1024)) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr[9:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr[9:0]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] op, input logic [15:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    vec_t v;
    v.we = we; v.op = op; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.lat = lat;
    return v;
  endfunction

  task automatic bus_xfer(input vec_t v);
    logic [32:0] e;
    logic        got;
    int          lat;
    @(posedge clk); #1;
    bus_if.bus_req_i   = 1'b1;
    bus_if.bus_we_i    = v.we;
    bus_if.bus_op_i    = v.op;
    bus_if.bus_addr_i  = v.addr;
    bus_if.bus_wdata_i = v.wdata;
    bus_if.bus_be_i    = v.be;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus_if.bus_gnt_o) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL gnt_timeout: addr 0x%04h got no grant within 50 cycles", v.addr);
      bus_if.bus_req_i = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    check("grant_sram_cs", 32'(sram_cs), 32'(!v.exp_err));
    @(posedge clk); #1;
    bus_if.bus_req_i = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus_if.bus_rvalid_o) got = 1'b1;
    end
    e = exp_q.pop_front();
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL rvalid_timeout: addr 0x%04h got no response within 20 cycles", v.addr);
      return;
    end
    check("rsp_latency", 32'(lat), 32'(v.lat));
    check("rsp_rdata", bus_if.bus_rdata_o, e[31:0]);
    check("rsp_err", 32'(bus_if.bus_err_o), 32'(e[32]));
  endtask

  task automatic clear_cnt();
    @(posedge clk); #1; cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
  endtask

  initial begin
    logic got;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[3] = 32'h0000_000F; mem[6] = 32'h0000_0066; mem[9] = 32'h0000_00FF;
    mem[16] = 32'h0000_1010; mem[32] = 32'h0000_2020;
    bus_if.bus_req_i = 1'b0; bus_if.bus_we_i = 1'b0; bus_if.bus_op_i = 2'b00;
    bus_if.bus_addr_i = '0; bus_if.bus_wdata_i = '0; bus_if.bus_be_i = '0;

    vecs[0]  = mk(1, 2'b00, 16'd5,    32'hAABBCCDD, 4'b0011, 32'h0, 0, 1);
    vecs[1]  = mk(0, 2'b00, 16'd5,    32'h0,        4'h0,    32'h0000CCDD, 0, 1);
    vecs[2]  = mk(1, 2'b00, 16'd7,    32'h12345678, 4'hF,    32'h0, 0, 1);
    vecs[3]  = mk(0, 2'b00, 16'd7,    32'h0,        4'h0,    32'h12345678, 0, 1);
    vecs[4]  = mk(1, 2'b00, 16'd7,    32'hCAFEBABE, 4'b1000, 32'h0, 0, 1);
    vecs[5]  = mk(0, 2'b00, 16'd7,    32'h0,        4'h0,    32'hCA345678, 0, 1);
    vecs[6]  = mk(1, 2'b01, 16'd3,    32'h00000100, 4'hF,    BITOP ? 32'hF : 32'h0, !BITOP, BITOP ? 2 : 1);
    vecs[7]  = mk(0, 2'b00, 16'd3,    32'h0,        4'h0,    BITOP ? 32'h10F : 32'hF, 0, 1);
    vecs[8]  = mk(0, 2'b00, 16'd1024, 32'h0,        4'h0,    32'h0, 1, 1);
    vecs[9]  = mk(1, 2'b00, 16'd1024, 32'hFFFFFFFF, 4'hF,    32'h0, 1, 1);
    vecs[10] = mk(1, 2'b11, 16'd4,    32'hFFFFFFFF, 4'hF,    32'h0, 1, 1);
    vecs[11] = mk(0, 2'b00, 16'd4,    32'h0,        4'h0,    32'h0, 0, 1);
    vecs[12] = mk(1, 2'b10, 16'd3,    32'h0000000F, 4'hF,    BITOP ? 32'h10F : 32'h0, !BITOP, BITOP ? 2 : 1);
    vecs[13] = mk(0, 2'b00, 16'd3,    32'h0,        4'h0,    BITOP ? 32'h100 : 32'hF, 0, 1);
    vecs[14] = mk(0, 2'b00, 16'hFFFF, 32'h0,        4'h0,    32'h0, 1, 1);
    vecs[15] = mk(0, 2'b11, 16'd6,    32'h0,        4'h0,    32'h66, 0, 1);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(bus_if.bus_gnt_o), 32'h0);
    check("rst_rvalid", 32'(bus_if.bus_rvalid_o), 32'h0);
    check("rst_err", 32'(bus_if.bus_err_o), 32'h0);
    check("rst_cnt", 32'(conflict_cnt), 32'h0);
    check("rst_sram_cs", 32'(sram_cs), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(TSMAP_ST_IDLE));
    @(posedge clk); #1; rst_n = 1'b1;

    for (int i = 0; i < 16; i++) bus_xfer(vecs[i]);

    // Revocation read and bus read collide: revocation wins, bus is granted next cycle.
    clear_cnt();
    fork
      bus_xfer(mk(0, 2'b00, 16'h20, 32'h0, 4'h0, 32'h2020, 0, 1));
      begin
        @(posedge clk); #1; trvk_cs = 1'b1; trvk_addr = 16'h10;
        @(negedge clk);
        check("prio_gnt", 32'(bus_if.bus_gnt_o), 32'h0);
        check("prio_sram_addr_trvk", 32'(sram_addr), 32'h10);
        @(posedge clk); #1; trvk_cs = 1'b0;
        @(negedge clk);
        check("prio_sram_addr_bus", 32'(sram_addr), 32'h20);
        check("prio_trvk_rdata", trvk_rdata, 32'h1010);
      end
    join
    check("prio_conflict_cnt", 32'(conflict_cnt), 32'h1);

`ifdef TSMAP_BITOP_EN
    // Bit-clear with the write phase blocked by three revocation reads of the same word.
    fork
      bus_xfer(mk(1, 2'b10, 16'd9, 32'h0000000F, 4'hF, 32'h000000FF, 0, 5));
      begin
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
          @(negedge clk);
          if (bus_if.bus_gnt_o) got = 1'b1;
        end
        @(posedge clk); #1; trvk_cs = 1'b1; trvk_addr = 16'd9;
        @(negedge clk);
        check("blk_no_write", 32'(sram_we), 32'h0);
        check("blk_state", 32'(dbg_state), 32'(TSMAP_ST_RMW_WR));
        @(posedge clk); #1;
        @(negedge clk);
        check("blk_trvk_old", trvk_rdata, 32'h000000FF);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1; trvk_cs = 1'b0;
        @(negedge clk);
        check("blk_write_we", 32'(sram_we), 32'h1);
        check("blk_write_data", sram_wdata, 32'h000000F0);
        check("blk_trvk_still_old", trvk_rdata, 32'h000000FF);
      end
    join
    bus_xfer(mk(0, 2'b00, 16'd9, 32'h0, 4'h0, 32'h000000F0, 0, 1));
`endif

    // Counter: linear count, saturation, and clear winning over increment.
    clear_cnt();
    @(posedge clk); #1;
    trvk_cs = 1'b1; trvk_addr = '0;
    bus_if.bus_req_i = 1'b1; bus_if.bus_we_i = 1'b0; bus_if.bus_addr_i = '0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("cnt_100", 32'(conflict_cnt), 32'd100);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    check("cnt_saturated", 32'(conflict_cnt), 32'hFFFF);
    @(posedge clk); #1; cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
    @(negedge clk);
    check("cnt_clr_priority", 32'(conflict_cnt), 32'h0);
    @(posedge clk); #1;
    bus_if.bus_req_i = 1'b0; trvk_cs = 1'b0;
    @(negedge clk);
    check("cnt_after_release", 32'(conflict_cnt), 32'h1);
    check("no_stray_rvalid", 32'(bus_if.bus_rvalid_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
